inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
Parametrised instruction-fetch stage for the multicycle core. It holds the PC and issues one read per instruction to a fixed-latency instruction memory. The fetched word and its next-sequential PC are presented to decode through a valid/ready handshake. The PC is updated on acceptance, either sequentially or from the branch target (ULA) when COND is set, and an asynchronous-in-time FLUSH redirect is supported.

Parameters:
ADDR_W, 16, width of PC / MEM_ADDR / NPC / ULA / FLUSH_PC
INST_W, 32, instruction width (MEM_OUT, IR)
MEM_LAT, 2, cycles from MEM_REQ cycle to MEM_OUT valid; legal range 1..15
RESET_PC, 0, PC value after reset
PC_STEP, 1, sequential PC increment

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous active-low reset
MEM_OUT  in  INST_W  instruction memory read data
MEM_ADDR  out  ADDR_W  memory address, always equals PC register
MEM_REQ  out  1  one-cycle read strobe
IR  out  INST_W  fetched instruction, registered
NPC  out  ADDR_W  fetched address + PC_STEP, registered with IR
IR_VALID  out  1  IR/NPC valid to decode
IR_READY  in  1  decode accepts IR
COND  in  1  branch taken, sampled on handshake
ULA  in  ADDR_W  branch target, sampled on handshake
FLUSH  in  1  redirect request, any state
FLUSH_PC  in  ADDR_W  redirect target
ESTADO  out  3  current state encoding (debug)
PERF_FETCH  out  32  accepted-instruction count (see Optional Feature)
PERF_STALL  out  32  IR_VALID && !IR_READY cycle count (see Optional Feature)

Behaviour:
- Reset (RST=0, asynchronous): STATE=IDLE, PC=RESET_PC, IR=0, NPC=0, IR_VALID=0, MEM_REQ=0, wait counter=0, discard flag=0, perf counters=0. MEM_ADDR=RESET_PC.
- All outputs are registered, except MEM_ADDR, which is a direct copy of PC. No output is combinational from inputs.
- States, with ESTADO encoding: IDLE=0, REQ=1, WAIT=2, CAPTURE=3, OUT=4. Values 5..7 are illegal and go to IDLE.
- IDLE: goes to REQ next cycle.
- REQ: MEM_REQ=1 for exactly this cycle. The counter is loaded with MEM_LAT-1. Go to WAIT if MEM_LAT>1, else to CAPTURE.
- WAIT: the counter decrements each cycle. At counter==1 go to CAPTURE.
- CAPTURE: this is cycle REQ+MEM_LAT. On the exit edge, MEM_OUT is registered into IR and PC+PC_STEP into NPC. Go to OUT, with IR_VALID=1 from the next cycle, unless the discard flag is set. In that case clear the flag, do not update IR or NPC, keep IR_VALID=0 and go to REQ.
- OUT: IR_VALID=1, and IR/NPC stay stable while IR_READY=0. On handshake (IR_VALID && IR_READY):
  - PC <= COND ? ULA : PC+PC_STEP.
  - IR_VALID <= 0.
  - Go to REQ.
- Latency: REQ to first IR_VALID is MEM_LAT+1 cycles. Back-to-back throughput is one instruction per MEM_LAT+2 cycles with IR_READY held at 1.
- FLUSH takes priority over everything except reset. When FLUSH=1 at a clock edge, PC <= FLUSH_PC, and:
  - in IDLE: continue to REQ;
  - in REQ/WAIT/CAPTURE: set the discard flag and complete the latency count (memory cannot be cancelled), then handle CAPTURE as above;
  - in OUT: IR_VALID <= 0, go to REQ, and ignore any coincident handshake (COND/ULA not used).
- FLUSH in the CAPTURE cycle drops that word.
- PC arithmetic is modulo 2^ADDR_W, so wrap from all-ones to 0 is legal and silent.
- Reset mid-operation immediately returns to the reset values. A memory response in flight is ignored.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: PERF_FETCH increments on each handshake, and PERF_STALL increments on each cycle with IR_VALID && !IR_READY. Both saturate at 2^32-1 and are cleared by reset only.
- Undefined: both ports are tied to 0, no counter flops are instantiated, and the port list is unchanged.

Decomposition:
- Package inst_fetch_pkg:
  - state encoding constants (IDLE..OUT);
  - ESTADO width;
  - counter width (4);
  - default ADDR_W/INST_W.
- Sub-module inst_fetch_perf: the two saturating counters, instantiated only under FETCH_PERF_EN.
- The FSM, PC and output registers remain in inst_fetch_unit.

Test Plan:
- Reset, MEM_LAT=2, IR_READY=1, MEM_OUT=32'hA0000000+MEM_ADDR → MEM_REQ pulses at addresses 0,1,2. IR=A0000000 with NPC=1, then A0000001 with NPC=2. IR_VALID asserts 3 cycles after each REQ, and the period is 4 cycles.
- IR_READY=0 for 5 cycles in OUT → IR/NPC stable, no MEM_REQ, PERF_STALL=5 (macro on). Then IR_READY=1 → handshake and next REQ at PC+1.
- Handshake with COND=1, ULA=16'h0040 → next MEM_ADDR=0x0040 and NPC of the following IR=0x0041. With COND=0 → PC+1.
- FLUSH=1, FLUSH_PC=16'h0100 in the WAIT cycle → no IR_VALID for the in-flight word, next REQ at 0x0100, and IR is the word from 0x0100.
- FLUSH together with handshake (COND=1, ULA=0x0040), FLUSH_PC=0x0200 → FLUSH wins, next REQ at 0x0200, PERF_FETCH not incremented.
- PC=16'hFFFF, COND=0 handshake → next REQ at 0x0000. RST=0 asserted asynchronously mid-WAIT → all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package inst_fetch_pkg;

  localparam int ESTADO_W   = 3;
  localparam int CNT_W      = 4;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_INST_W = 32;

  typedef enum logic [ESTADO_W-1:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_OUT     = 3'd4
  } state_t;

endpackage

// File: rtl/inst_fetch_perf.sv
// Saturating fetch/stall event counters for the fetch stage.
module inst_fetch_perf (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch_inc && fetch_cnt != '1) fetch_cnt <= fetch_cnt + 32'd1;
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Multicycle instruction-fetch stage: PC, fixed-latency memory read, valid/ready to decode.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module inst_fetch_unit
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int INST_W   = DEF_INST_W,
  parameter int MEM_LAT  = 2,
  parameter int RESET_PC = 0,
  parameter int PC_STEP  = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [INST_W-1:0]   MEM_OUT,
  output logic [ADDR_W-1:0]   MEM_ADDR,
  output logic                MEM_REQ,
  output logic [INST_W-1:0]   IR,
  output logic [ADDR_W-1:0]   NPC,
  output logic                IR_VALID,
  input  logic                IR_READY,
  input  logic                COND,
  input  logic [ADDR_W-1:0]   ULA,
  input  logic                FLUSH,
  input  logic [ADDR_W-1:0]   FLUSH_PC,
  output logic [ESTADO_W-1:0] ESTADO,
  output logic [31:0]         PERF_FETCH,
  output logic [31:0]         PERF_STALL
);

  localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
  localparam logic [CNT_W-1:0]  LAT_M1  = CNT_W'(MEM_LAT - 1);

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc;
  logic [CNT_W-1:0]   cnt;
  logic               discard;
  logic               handshake;
  logic               capture;

  assign MEM_ADDR = pc;
  assign ESTADO   = state;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    handshake = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE:    state_nxt = S_REQ;
      S_REQ:     state_nxt = (MEM_LAT > 1) ? S_WAIT : S_CAPTURE;
      S_WAIT:    if (cnt == CNT_W'(1)) state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        // A flush landing on the capture edge drops the word just like a pending one.
        if (discard || FLUSH) state_nxt = S_REQ;
        else begin
          state_nxt = S_OUT;
          capture   = 1'b1;
        end
      end
      S_OUT: begin
        if (FLUSH) state_nxt = S_REQ;
        else if (IR_VALID && IR_READY) begin
          state_nxt = S_REQ;
          handshake = 1'b1;
        end
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc       <= PC_RST;
      IR       <= '0;
      NPC      <= '0;
      IR_VALID <= 1'b0;
      MEM_REQ  <= 1'b0;
      cnt      <= '0;
      discard  <= 1'b0;
    end else begin
      MEM_REQ  <= (state_nxt == S_REQ);
      IR_VALID <= (state_nxt == S_OUT);

      if (state == S_REQ)       cnt <= LAT_M1;
      else if (state == S_WAIT) cnt <= cnt - CNT_W'(1);

      if (capture) begin
        IR  <= MEM_OUT;
        NPC <= pc + STEP;
      end

      if (FLUSH)          pc <= FLUSH_PC;
      else if (handshake) pc <= COND ? ULA : pc + STEP;

      // The memory read cannot be cancelled, so a flush only marks its word as stale.
      if (state == S_CAPTURE)
        discard <= 1'b0;
      else if (FLUSH && (state == S_REQ || state == S_WAIT))
        discard <= 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  inst_fetch_perf u_perf (
    .gclk      (CLK),
    .grst_n    (RST),
    .fetch_inc (handshake),
    .stall_inc (IR_VALID && !IR_READY),
    .fetch_cnt (PERF_FETCH),
    .stall_cnt (PERF_STALL)
  );
`else
  assign PERF_FETCH = '0;
  assign PERF_STALL = '0;
`endif

endmodule
